// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent LSB-first as
// start, data, optional parity and 1 or 2 stop bits at p_CLK_DIV clocks per bit.
module uart_tx #(
   parameter int p_CLK_DIV   = 104,
   parameter int p_WORD_LEN  = 8,
   parameter int p_PARITY    = 0,
   parameter int p_STOP_BITS = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [p_WORD_LEN-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CW = ($clog2(p_CLK_DIV) > 1) ? $clog2(p_CLK_DIV) : 1;
   localparam int BW = ($clog2(p_WORD_LEN + 1) > 1) ? $clog2(p_WORD_LEN + 1) : 1;
   // out-of-range parity / stop settings fall back to "none" / one stop bit
   localparam logic PAR_EN  = (p_PARITY == 1) || (p_PARITY == 2);
   localparam logic PAR_ODD = (p_PARITY == 1);
   localparam int   STOPS   = (p_STOP_BITS == 2) ? 2 : 1;

   localparam logic [CW-1:0] CLK_LAST  = CW'(p_CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(p_WORD_LEN - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOPS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [p_WORD_LEN-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  bit_end;
   logic [CW-1:0]         clk_cnt_inc;
   logic [p_WORD_LEN-1:0] shift_nxt;

   assign bit_end     = (clk_cnt_q == CLK_LAST);
   assign clk_cnt_inc = bit_end ? '0 : clk_cnt_q + CW'(1);
   assign shift_nxt   = shift_q >> 1;

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (i_valid && ready_q) begin
               shift_d   = i_data;
               par_d     = (^i_data) ^ PAR_ODD;
               state_d   = S_START;
               clk_cnt_d = '0;
               tx_d      = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
            end
         end
         S_START: begin
            clk_cnt_d = clk_cnt_inc;
            if (bit_end) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
            end
         end
         S_DATA: begin
            clk_cnt_d = clk_cnt_inc;
            if (bit_end) begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  if (PAR_EN) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  shift_d   = shift_nxt;
                  tx_d      = shift_nxt[0];
               end
            end
         end
         S_PARITY: begin
            clk_cnt_d = clk_cnt_inc;
            if (bit_end) begin
               state_d   = S_STOP;
               bit_cnt_d = '0;
               tx_d      = 1'b1;
            end
         end
         S_STOP: begin
            clk_cnt_d = clk_cnt_inc;
            tx_d      = 1'b1;
            // bit_cnt doubles as the stop-bit index here
            if (bit_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  state_d   = S_IDLE;
                  bit_cnt_d = '0;
                  ready_d   = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            ready_d   = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_tx    = tx_q;
   assign o_ready = ready_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/2 stop, odd/2 stop)
// share one input stream and are compared every cycle against a frame-level model.
module tb_uart_tx;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic [7:0] data;
   logic [2:0] tx, rdy, busy, done;

   always #5 clk = ~clk;

   uart_tx #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(0), .p_STOP_BITS(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
   uart_tx #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(2), .p_STOP_BITS(2)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
   uart_tx #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(1), .p_STOP_BITS(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

   int cp [3] = '{0, 2, 1};
   int cs [3] = '{1, 2, 2};

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: on accept, expand the frame into a per-cycle line waveform
   // and replay it; the block is ready again once the waveform is exhausted.
   logic mf   [3][64];
   int   mlen [3];
   int   mpos [3];
   logic mact [3];
   logic mtx  [3];
   logic mrdy [3];
   logic mbusy[3];
   logic mdone[3];
   logic fb   [12];
   int   nb;
   int   cyc = 0;

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            mtx[d] = 1'b1; mrdy[d] = 1'b0; mbusy[d] = 1'b0; mdone[d] = 1'b0; mact[d] = 1'b0;
         end else begin
            mdone[d] = 1'b0;
            if (mact[d]) begin
               mpos[d]++;
               if (mpos[d] == mlen[d]) begin
                  mact[d] = 1'b0; mtx[d] = 1'b1; mrdy[d] = 1'b1; mbusy[d] = 1'b0; mdone[d] = 1'b1;
               end else begin
                  mtx[d] = mf[d][mpos[d]];
               end
            end else if (mrdy[d] && valid) begin
               fb[0] = 1'b0;
               for (int i = 0; i < 8; i++) fb[1+i] = data[i];
               nb = 9;
               if (cp[d] != 0) begin
                  fb[nb] = (^data) ^ (cp[d] == 1);
                  nb++;
               end
               for (int s = 0; s < cs[d]; s++) begin
                  fb[nb] = 1'b1;
                  nb++;
               end
               for (int j = 0; j < nb; j++)
                  for (int r = 0; r < DIV; r++) mf[d][j*DIV+r] = fb[j];
               mlen[d] = nb * DIV;
               mpos[d] = 0;
               mact[d] = 1'b1; mtx[d] = mf[d][0]; mrdy[d] = 1'b0; mbusy[d] = 1'b1;
            end else begin
               mrdy[d] = 1'b1; mtx[d] = 1'b1;
            end
         end
      end
   end

   // per-instance capture of the line while busy, done count and frame latency
   logic hist [3][64];
   int   hidx [3];
   int   st   [3];
   int   lat  [3];
   int   ndone[3] = '{0, 0, 0};
   logic pb   [3] = '{1'b0, 1'b0, 1'b0};
   logic chk_en = 1'b0;

   function automatic logic [9:0] frame_bits(input int d);
      logic [9:0] v;
      for (int j = 0; j < 10; j++) v[j] = hist[d][j*DIV+1];
      return v;
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(&rdy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(&rdy)) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [7:0] w);
      int n = 0;
      while (!(&rdy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(&rdy)) check("send_timeout", 32'd0, 32'd1);
      valid = 1'b1;
      data  = w;
      @(negedge clk);
      valid = 1'b0;
      data  = 8'($urandom);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int base;
   int n;

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 8'h00;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               for (int d = 0; d < 3; d++) begin
                  if (busy[d] && !pb[d]) begin
                     hidx[d] = 0;
                     st[d]   = cyc;
                  end
                  if (busy[d] && hidx[d] < 64) begin
                     hist[d][hidx[d]] = tx[d];
                     hidx[d]++;
                  end
                  if (done[d]) begin
                     ndone[d]++;
                     lat[d] = cyc - st[d];
                  end
                  pb[d] = busy[d];
                  check($sformatf("line_dut%0d", d), {tx[d], rdy[d], busy[d], done[d]},
                        {mtx[d], mrdy[d], mbusy[d], mdone[d]});
               end
            end
         end
      join_none

      @(posedge clk);
      chk_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", rdy, 3'b000);
         check("rst_tx", tx, 3'b111);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", rdy, 3'b111);
      check("no_done_rst", ndone[0] + ndone[1] + ndone[2], 0);

      // basic frame and parity words
      base = ndone[0];
      send(8'hA5);
      wait_idle();
      check("a5_frame", frame_bits(0), 10'b1101001010);
      check("a5_latency", lat[0], 40);
      check("a5_done_cnt", ndone[0] - base, 1);
      check("a5_even_par", hist[1][37], 1'b0);
      check("a5_odd_par", hist[2][37], 1'b1);

      send(8'h07);
      wait_idle();
      check("07_even_par", hist[1][37], 1'b1);
      check("07_odd_par", hist[2][37], 1'b0);
      check("07_latency_2stop", lat[1], 48);

      send(8'h00);
      wait_idle();
      check("00_even_par", hist[1][37], 1'b0);
      check("00_odd_par", hist[2][37], 1'b1);

      // valid pulse while busy must be dropped
      base = ndone[0];
      send(8'h00);
      repeat (20) @(negedge clk);
      valid = 1'b1;
      data  = 8'hFF;
      @(negedge clk);
      valid = 1'b0;
      wait_idle();
      check("busy_ign_done", ndone[0] - base, 1);
      check("busy_ign_frame", frame_bits(0), 10'b1000000000);

      // back-to-back with valid held; data churns mid-frame
      valid = 1'b1;
      data  = 8'h3C;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy[0] && n < 10);
      check("b2b_accept1", busy[0], 1'b1);
      n = 0;
      while (!done[0] && n < 60) begin
         data = 8'($urandom);
         @(negedge clk);
         n++;
      end
      check("b2b_done1_seen", done[0], 1'b1);
      data = 8'hC3;
      @(negedge clk);
      check("b2b_latency1", lat[0], 40);
      check("b2b_accept_on_done", busy[0], 1'b1);
      valid = 1'b0;
      data  = 8'($urandom);
      wait_idle();
      check("b2b_frame2", frame_bits(0), 10'b1110000110);

      // reset during data bit 3
      base = ndone[0];
      send(8'h55);
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_tx", tx, 3'b111);
      check("mrst_ready", rdy, 3'b000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mrst_no_done", ndone[0] - base, 0);
      send(8'h81);
      wait_idle();
      check("81_frame", frame_bits(0), 10'b1100000010);
      check("81_done_cnt", ndone[0] - base, 1);

      // randomized words, gaps and stray valid pulses
      for (int k = 0; k < 25; k++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         send(8'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            valid = 1'b1;
            data  = 8'($urandom);
            @(negedge clk);
            valid = 1'b0;
         end
      end
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
